// File: rtl/tdm_demux4.sv
// Receive-side demultiplexer for a 4-channel TDM link: recovers slot alignment
// from the slot-0 sync strobe and presents each complete frame as registered parallel words.
module tdm_demux4 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             sync,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic             valid,
  output logic [1:0]       slot,
  output logic             locked,
  output logic             sync_err
);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [WIDTH-1:0] shadow0_q, shadow0_d;
  logic [WIDTH-1:0] shadow1_q, shadow1_d;
  logic [WIDTH-1:0] shadow2_q, shadow2_d;
  logic [WIDTH-1:0] out0_q, out0_d;
  logic [WIDTH-1:0] out1_q, out1_d;
  logic [WIDTH-1:0] out2_q, out2_d;
  logic [WIDTH-1:0] out3_q, out3_d;
  logic             valid_q, valid_d;
  logic             sync_err_q, sync_err_d;

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    shadow0_d  = shadow0_q;
    shadow1_d  = shadow1_q;
    shadow2_d  = shadow2_q;
    out0_d     = out0_q;
    out1_d     = out1_q;
    out2_d     = out2_q;
    out3_d     = out3_q;
    valid_d    = 1'b0;
    sync_err_d = 1'b0;

    unique case (state_q)
      HUNT: begin
        if (sync) begin
          shadow0_d = in_data;
          slot_d    = 2'd1;
          state_d   = LOCKED;
        end else begin
          slot_d = 2'd0;
        end
      end

      LOCKED: begin
        if (sync && (slot_q != 2'd0)) begin
          // Realign: this word becomes slot 0, the partial frame is dropped.
          shadow0_d  = in_data;
          slot_d     = 2'd1;
          sync_err_d = 1'b1;
        end else begin
          slot_d = slot_q + 2'd1;
          unique case (slot_q)
            2'd0: shadow0_d = in_data;
            2'd1: shadow1_d = in_data;
            2'd2: shadow2_d = in_data;
            2'd3: begin
              out0_d  = shadow0_q;
              out1_d  = shadow1_q;
              out2_d  = shadow2_q;
              out3_d  = in_data;
              valid_d = 1'b1;
            end
            default: ;
          endcase
        end
      end

      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HUNT;
      slot_q     <= '0;
      shadow0_q  <= '0;
      shadow1_q  <= '0;
      shadow2_q  <= '0;
      out0_q     <= '0;
      out1_q     <= '0;
      out2_q     <= '0;
      out3_q     <= '0;
      valid_q    <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      shadow0_q  <= shadow0_d;
      shadow1_q  <= shadow1_d;
      shadow2_q  <= shadow2_d;
      out0_q     <= out0_d;
      out1_q     <= out1_d;
      out2_q     <= out2_d;
      out3_q     <= out3_d;
      valid_q    <= valid_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign out0     = out0_q;
  assign out1     = out1_q;
  assign out2     = out2_q;
  assign out3     = out3_q;
  assign valid    = valid_q;
  assign slot     = slot_q;
  assign locked   = (state_q == LOCKED);
  assign sync_err = sync_err_q;

endmodule
